// File: rtl/main_fsm_pkg.sv
// Shared control definitions for the multicycle core: state encoding,
// opcode constants, datapath select encodings and the control word layout.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Opcodes the decoder knows how to sequence; anything else is flagged.
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BRANCH);
  endfunction

  // Final state of every instruction; leaving it retires the instruction.
  function automatic logic state_retires(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) || (s == S_BEQ);
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs).
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Every field defaults to 0 so unused selects are deterministic.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM: state register, next-state logic, sticky
// illegal-opcode flag and retired-instruction counter.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic                 Illegal,
  output logic [INSTRET_W-1:0] Instret
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BRANCH:    state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMREAD;
        else if (op == OP_SW) state_next = S_MEMWRITE;
        else                  state_next = S_FETCH;
      end
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Bring-up status: count retirements, latch any unsupported opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      Instret <= '0;
      Illegal <= 1'b0;
    end else begin
      if (state_retires(state))
        Instret <= Instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      if ((state == S_DECODE) && !op_supported(op))
        Illegal <= 1'b1;
    end
  end

  main_fsm_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Reset masks every enable and select so nothing moves during reset.
  always_comb begin
    ctrl_out = ctrl;
    if (reset) ctrl_out = CTRL_IDLE;
  end

  assign PCUpdate  = ctrl_out.pc_update;
  assign Branch    = ctrl_out.branch;
  assign RegWrite  = ctrl_out.reg_write;
  assign MemWrite  = ctrl_out.mem_write;
  assign IRWrite   = ctrl_out.ir_write;
  assign AdrSrc    = ctrl_out.adr_src;
  assign ResultSrc = ctrl_out.result_src;
  assign ALUSrcA   = ctrl_out.alu_src_a;
  assign ALUSrcB   = ctrl_out.alu_src_b;
  assign ALUOp     = ctrl_out.alu_op;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios plus a random
// instruction stream compared against an instruction-level reference model.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;

  logic        PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [31:0] Instret;

  logic        w4_pcu, w4_br, w4_rw, w4_mw, w4_irw, w4_adr, w4_ill;
  logic [1:0]  w4_res, w4_a, w4_b, w4_aluop;
  logic [3:0]  Instret4;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          ref_cnt = 0;
  logic        ref_ill = 1'b0;

  always #5 clk = ~clk;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Illegal(Illegal), .Instret(Instret)
  );

  main_fsm #(.INSTRET_W(4)) dut4 (
    .clk(clk), .reset(reset), .op(op),
    .PCUpdate(w4_pcu), .Branch(w4_br), .RegWrite(w4_rw), .MemWrite(w4_mw),
    .IRWrite(w4_irw), .AdrSrc(w4_adr), .ResultSrc(w4_res), .ALUSrcA(w4_a),
    .ALUSrcB(w4_b), .ALUOp(w4_aluop), .Illegal(w4_ill), .Instret(Instret4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word as {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  function automatic logic [13:0] mk(input logic pcu, input logic br, input logic rw,
                                     input logic mw, input logic irw, input logic adr,
                                     input logic [1:0] res, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] aluop);
    return {pcu, br, rw, mw, irw, adr, res, a, b, aluop};
  endfunction

  function automatic logic [13:0] observed();
    return {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  // Instruction classes: 0 LW, 1 SW, 2 R, 3 I, 4 JAL, 5 BRANCH, 6 illegal
  function automatic int classify(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic int cpi(input int cls);
    case (cls)
      0: return 5;
      5: return 3;
      6: return 2;
      default: return 4;
    endcase
  endfunction

  // Expected control word in cycle c (0 = fetch) of an instruction of class cls.
  function automatic logic [13:0] exp_word(input int cls, input int c);
    logic [13:0] fetch_w, decode_w, alu_wb;
    fetch_w  = mk(1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    decode_w = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    alu_wb   = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    if (c == 0) return fetch_w;
    if (c == 1) return decode_w;
    case (cls)
      0: case (c)
           2: return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
           3: return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
           default: return mk(0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
         endcase
      1: if (c == 2) return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
         else        return mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      2: if (c == 2) return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
         else        return alu_wb;
      3: if (c == 2) return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
         else        return alu_wb;
      4: if (c == 2) return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
         else        return alu_wb;
      5: return mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
      default: return '0;
    endcase
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_instret"}, Instret, ref_cnt);
    chk({tag, "_instret4"}, {28'd0, Instret4}, ref_cnt % 16);
    chk({tag, "_illegal"}, {31'd0, Illegal}, {31'd0, ref_ill});
  endtask

  // Runs one instruction starting just after the edge entering FETCH.
  // abort_at >= 0 asserts reset during that cycle instead of finishing.
  task automatic run_instr(input logic [6:0] op_v, input int abort_at);
    int cls, len;
    cls = classify(op_v);
    len = cpi(cls);
    for (int c = 0; c < len; c++) begin
      if (c == 1 || c == 2) op = op_v;
      else                  op = 7'($urandom);
      if (c == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("abort_ctrl_c%0d", c), {18'd0, observed()}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        ref_cnt = 0;
        ref_ill = 1'b0;
        return;
      end
      @(negedge clk);
      chk($sformatf("ctrl_cls%0d_c%0d", cls, c), {18'd0, observed()}, {18'd0, exp_word(cls, c)});
      check_status($sformatf("st_cls%0d_c%0d", cls, c));
      @(posedge clk);
      if (cls == 6 && c == 1) ref_ill = 1'b1;
      if (cls != 6 && c == len - 1) ref_cnt++;
      #2;
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] tbl [6];
    tbl[0] = 7'b0000011; tbl[1] = 7'b0100011; tbl[2] = 7'b0110011;
    tbl[3] = 7'b0010011; tbl[4] = 7'b1101111; tbl[5] = 7'b1100011;
    if ($urandom_range(0, 7) < 6) return tbl[$urandom_range(0, 5)];
    return 7'($urandom);
  endfunction

  initial begin
    reset = 1'b1;
    op = 7'd0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst1_ctrl", {18'd0, observed()}, 32'd0);
    check_status("rst1");
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst2_ctrl", {18'd0, observed()}, 32'd0);
    check_status("rst2");
    @(posedge clk); #2;
    reset = 1'b0;

    // directed sequence
    run_instr(7'b0000011, -1);  // LW
    run_instr(7'b0100011, -1);  // SW
    run_instr(7'b0110011, -1);  // R-type
    chk("after_sw_r_instret", Instret, 32'd3);
    run_instr(7'b1100011, -1);  // branch
    run_instr(7'b1101111, -1);  // JAL
    run_instr(7'b1111111, -1);  // illegal
    run_instr(7'b0000011, -1);  // LW after illegal
    chk("illegal_sticky", {31'd0, Illegal}, 32'd1);
    chk("illegal_not_counted", Instret, 32'd6);

    // reset during MEMREAD of a load
    run_instr(7'b0000011, 3);
    run_instr(7'b0010011, -1);  // I-type, first after abort
    chk("after_abort_instret", Instret, 32'd1);

    // random instruction stream with occasional aborts
    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      int ab;
      o = rand_op();
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, cpi(classify(o)) - 1) : -1;
      run_instr(o, ab);
    end

    // wrap of the narrow counter
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    ref_cnt = 0;
    ref_ill = 1'b0;
    for (int n = 0; n < 16; n++) run_instr(7'b0110011, -1);
    chk("wrap_instret4", {28'd0, Instret4}, 32'd0);
    chk("wrap_instret32", Instret, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
